// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART word scheduler.
// UART_TX_SCHED_TAG_EN adds the WAIT_TAG state for tagged words.
package uart_tx_sched_pkg;

    localparam logic [3:0] TAG_NIBBLE = 4'hA;
    localparam int         MAX_REQ    = 16;

`ifdef UART_TX_SCHED_TAG_EN
    typedef enum logic [1:0] {
        IDLE,
        WAIT_TAG,
        WAIT_HI,
        WAIT_LO
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO
    } state_t;
`endif

endpackage

// File: rtl/uart_tx_word_sched_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// Outputs a one-hot grant, its index and a valid flag.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Walk offsets from far to near so the nearest request wins.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                idx = IW'((int'(ptr) + i) % N);
            end
        end
        valid      = |req;
        grant      = '0;
        grant[idx] = valid;
    end

endmodule

// File: rtl/uart_tx_word_sched.sv
// Shares one byte UART between N_REQ 16-bit word requesters.
// Define UART_TX_SCHED_TAG_EN to prefix each word with a tag byte.
module uart_tx_word_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  i_req,
    input  logic [16*N_REQ-1:0] i_data,
    output logic [N_REQ-1:0]  o_ack,
    output logic              o_tx_en,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_done,
    output logic              o_busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state, state_n;
    logic [IW-1:0]    ptr, ptr_n;
    logic [7:0]       lo_q, lo_n;
`ifdef UART_TX_SCHED_TAG_EN
    logic [7:0]       hi_q, hi_n;
`endif
    logic [N_REQ-1:0] ack_n;
    logic             tx_en_n;
    logic [7:0]       tx_data_n;
    logic             busy_n;

    logic [N_REQ-1:0] g_onehot;
    logic [IW-1:0]    g_idx;
    logic             g_valid;
    logic [15:0]      g_word;
    logic             done_ok;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req   (i_req),
        .ptr   (ptr),
        .grant (g_onehot),
        .idx   (g_idx),
        .valid (g_valid)
    );

    assign g_word  = i_data[16*g_idx +: 16];
    // A done landing on an issue cycle cannot belong to the new byte.
    assign done_ok = i_tx_done && !o_tx_en;

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        lo_n      = lo_q;
`ifdef UART_TX_SCHED_TAG_EN
        hi_n      = hi_q;
`endif
        ack_n     = '0;
        tx_en_n   = 1'b0;
        tx_data_n = o_tx_data;
        busy_n    = o_busy;
        unique case (state)
            IDLE: begin
                if (g_valid) begin
                    lo_n    = g_word[7:0];
                    ack_n   = g_onehot;
                    tx_en_n = 1'b1;
                    busy_n  = 1'b1;
                    if (g_idx == IW'(N_REQ - 1))
                        ptr_n = '0;
                    else
                        ptr_n = g_idx + IW'(1);
`ifdef UART_TX_SCHED_TAG_EN
                    hi_n      = g_word[15:8];
                    tx_data_n = {TAG_NIBBLE, 4'(g_idx)};
                    state_n   = WAIT_TAG;
`else
                    tx_data_n = g_word[15:8];
                    state_n   = WAIT_HI;
`endif
                end
            end
`ifdef UART_TX_SCHED_TAG_EN
            WAIT_TAG: begin
                if (done_ok) begin
                    tx_en_n   = 1'b1;
                    tx_data_n = hi_q;
                    state_n   = WAIT_HI;
                end
            end
`endif
            WAIT_HI: begin
                if (done_ok) begin
                    tx_en_n   = 1'b1;
                    tx_data_n = lo_q;
                    state_n   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (done_ok) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            lo_q      <= '0;
`ifdef UART_TX_SCHED_TAG_EN
            hi_q      <= '0;
`endif
            o_ack     <= '0;
            o_tx_en   <= 1'b0;
            o_tx_data <= 8'h00;
            o_busy    <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            lo_q      <= lo_n;
`ifdef UART_TX_SCHED_TAG_EN
            hi_q      <= hi_n;
`endif
            o_ack     <= ack_n;
            o_tx_en   <= tx_en_n;
            o_tx_data <= tx_data_n;
            o_busy    <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_word_sched.sv
// Directed bench for uart_tx_word_sched with a simple UART responder.
// Expected bytes follow UART_TX_SCHED_TAG_EN when it is defined.
module tb_uart_tx_word_sched;

`ifdef UART_TX_SCHED_TAG_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  i_req;
    logic [63:0] i_data;
    logic [3:0]  o_ack;
    logic        o_tx_en;
    logic [7:0]  o_tx_data;
    logic        i_tx_done;
    logic        o_busy;

    logic        auto_done;
    logic        stray_done;
    logic        uart_auto;
    int          cnt;
    int          nchk;
    int          nerr;
    int          n;
    int          n0;
    logic [7:0]  bytes[$];
    int          grants[$];

    assign i_tx_done = auto_done | stray_done;

    uart_tx_word_sched #(.N_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_data    (i_data),
        .o_ack     (o_ack),
        .o_tx_en   (o_tx_en),
        .o_tx_data (o_tx_data),
        .i_tx_done (i_tx_done),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: log each byte, answer done 4 cycles after tx_en.
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt       = 0;
            auto_done = 1'b0;
        end else begin
            auto_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) auto_done = 1'b1;
            end
            if (o_tx_en) begin
                bytes.push_back(o_tx_data);
                if (uart_auto) cnt = 4;
            end
            for (int k = 0; k < 4; k++)
                if (o_ack[k]) grants.push_back(k);
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    function automatic logic [7:0] exp_byte(input int g,
                                            input logic [15:0] w,
                                            input int i);
`ifdef UART_TX_SCHED_TAG_EN
        if (i == 0) return {4'hA, 4'(g)};
        if (i == 1) return w[15:8];
        return w[7:0];
`else
        if (i == 0) return w[15:8];
        return w[7:0];
`endif
    endfunction

    task automatic check_word(input string tag, input int g,
                              input logic [15:0] w, input int base);
        for (int i = 0; i < NB; i++) begin
            if (base + i < bytes.size())
                check(tag, {24'h0, bytes[base+i]}, {24'h0, exp_byte(g, w, i)});
            else
                check(tag, 32'hffff_ffff, {24'h0, exp_byte(g, w, i)});
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (o_busy && k < 300) begin
            step;
            k++;
        end
        check(tag, {31'h0, o_busy}, 32'h0);
    endtask

    task automatic wait_acks(input string tag, input int target);
        int k;
        k = 0;
        while (grants.size() < target && k < 300) begin
            step;
            k++;
        end
        check(tag, grants.size(), target);
    endtask

    task automatic pulse_done;
        stray_done = 1'b1;
        step;
        stray_done = 1'b0;
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        rst_n = 1'b0;
        i_req = '0;
        i_data = '0;
        stray_done = 1'b0;
        uart_auto = 1'b1;
        repeat (3) step;
        check("rst_ack", {28'h0, o_ack}, 32'h0);
        check("rst_tx_en", {31'h0, o_tx_en}, 32'h0);
        check("rst_tx_data", {24'h0, o_tx_data}, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        rst_n = 1'b1;
        step;

        // fairness from pointer 0
        bytes.delete();
        grants.delete();
        i_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        i_req = 4'b1111;
        wait_acks("fair_acks", 5);
        i_req = '0;
        wait_idle("fair_idle");
        check("fair_g0", grants[0], 0);
        check("fair_g1", grants[1], 1);
        check("fair_g2", grants[2], 2);
        check("fair_g3", grants[3], 3);
        check("fair_g4", grants[4], 0);
        check("fair_nbytes", bytes.size(), 5 * NB);
        check_word("fair_w0", 0, 16'h1111, 0);
        check_word("fair_w1", 1, 16'h2222, NB);
        check_word("fair_w2", 2, 16'h3333, 2 * NB);
        check_word("fair_w3", 3, 16'h4444, 3 * NB);
        check_word("fair_w4", 0, 16'h1111, 4 * NB);
        step;

        // single word, timing of ack/tx_en/busy
        bytes.delete();
        grants.delete();
        i_data[15:0] = 16'hA55A;
        i_req = 4'b0001;
        step;
        check("one_ack", {28'h0, o_ack}, 32'h1);
        check("one_tx_en", {31'h0, o_tx_en}, 32'h1);
        check("one_b0", {24'h0, o_tx_data},
              {24'h0, exp_byte(0, 16'hA55A, 0)});
        check("one_busy", {31'h0, o_busy}, 32'h1);
        i_req = '0;
        step;
        check("one_ack_w", {28'h0, o_ack}, 32'h0);
        check("one_en_w", {31'h0, o_tx_en}, 32'h0);
        n = 1;
        while (o_busy && n < 200) begin
            step;
            n++;
        end
        check("one_busy_len", n, 5 * NB);
        check("one_nbytes", bytes.size(), NB);
        check_word("one_word", 0, 16'hA55A, 0);
        step;

        // pointer wrap: req 2 moves pointer to 3, then 0 before 2
        grants.delete();
        bytes.delete();
        i_req = 4'b0100;
        wait_acks("wrap_a1", 1);
        i_req = '0;
        wait_idle("wrap_i1");
        i_req = 4'b0101;
        wait_acks("wrap_a3", 3);
        i_req = '0;
        wait_idle("wrap_i2");
        check("wrap_g0", grants[0], 2);
        check("wrap_g1", grants[1], 0);
        check("wrap_g2", grants[2], 2);
        step;

        // stray done pulses, manual UART
        uart_auto = 1'b0;
        bytes.delete();
        pulse_done;
        check("stray_idle_busy", {31'h0, o_busy}, 32'h0);
        check("stray_idle_en", {31'h0, o_tx_en}, 32'h0);
        i_req = 4'b0010;
        step;
        check("stray_ack", {28'h0, o_ack}, 32'h2);
        check("stray_b0", {24'h0, o_tx_data},
              {24'h0, exp_byte(1, 16'h2222, 0)});
        i_req = '0;
        pulse_done;
        check("stray_en_en", {31'h0, o_tx_en}, 32'h0);
        check("stray_en_busy", {31'h0, o_busy}, 32'h1);
        repeat (3) step;
        check("stray_nbytes", bytes.size(), 1);
        for (int i = 1; i < NB; i++) begin
            pulse_done;
            check("stray_en", {31'h0, o_tx_en}, 32'h1);
            check("stray_b", {24'h0, o_tx_data},
                  {24'h0, exp_byte(1, 16'h2222, i)});
        end
        step;
        check("stray_still_busy", {31'h0, o_busy}, 32'h1);
        pulse_done;
        check("stray_done_busy", {31'h0, o_busy}, 32'h0);
        uart_auto = 1'b1;
        step;

        // reset while in the last byte
        bytes.delete();
        i_data[15:0] = 16'h1234;
        i_req = 4'b0001;
        step;
        i_req = '0;
        n = 0;
        while (bytes.size() < NB && n < 100) begin
            step;
            n++;
        end
        check("mid_nbytes", bytes.size(), NB);
        check("mid_busy", {31'h0, o_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, o_busy}, 32'h0);
        check("mid_rst_en", {31'h0, o_tx_en}, 32'h0);
        check("mid_rst_data", {24'h0, o_tx_data}, 32'h0);
        check("mid_rst_ack", {28'h0, o_ack}, 32'h0);
        repeat (2) step;
        rst_n = 1'b1;
        step;
        n0 = bytes.size();
        repeat (10) step;
        check("mid_no_tx", bytes.size(), n0);
        bytes.delete();
        grants.delete();
        i_data[63:48] = 16'hCAFE;
        i_req = 4'b0011;
        wait_acks("post_a1", 1);
        i_req = '0;
        wait_idle("post_i1");
        i_req = 4'b1000;
        wait_acks("post_a2", 2);
        i_req = '0;
        wait_idle("post_i2");
        check("post_g0", grants[0], 0);
        check("post_g1", grants[1], 3);
        check_word("post_w3", 3, 16'hCAFE, NB);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
